// File: rtl/dlx_pkg.sv
// Shared DLX definitions: fetch FSM states, opcode constants and fetch defaults.
// Optional misaligned-redirect trap is enabled with FETCH_MISALIGN_TRAP_EN.
package dlx_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OP_TRAP          = 6'b010001;
    localparam logic [5:0]  OP_NOP           = 6'b010101;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;
    localparam logic [31:0] DEFAULT_NOP_WORD = {OP_NOP, 26'd0};

    function automatic logic is_trap(input logic [5:0] opcode);
        return opcode == OP_TRAP;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port between the fetch stage (master) and memory (slave).
interface instr_fetch_if;
    logic        imem_cs;
    logic        imem_oe;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [0:31] imem_dout;

    modport master (output imem_cs, imem_oe, imem_we, imem_addr, input imem_dout);
    modport slave  (input imem_cs, imem_oe, imem_we, imem_addr, output imem_dout);
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection (reset / redirect / hold / +4)
// and the PC+4 adder shared with the IF/ID register.
module fetch_pc_gen
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;

    // Modulo-2^32 add: the top word wraps to zero silently.
    assign pc4 = pc_reg + 32'd4;
    assign pc  = pc_reg;

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = target;
        end else if (advance) begin
            pc_next = pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// DLX instruction-fetch stage: START/RUN/HALT FSM, IF/ID register, redirect squash.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module instr_fetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    instr_fetch_if.master        imem,
    output logic [0:31]          if_id_instr,
    output logic [31:0]          if_id_pc4,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic                 fetch_misalign
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic         capture;
    logic         port_en;
    logic         redirect_misaligned;
    logic [31:0]  target;
    logic [31:0]  pc;
    logic [31:0]  pc4;
    logic [0:31]  if_id_instr_reg;
    logic [31:0]  if_id_pc4_reg;
    logic         if_id_valid_reg;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_reg;

    assign redirect_misaligned = redirect && (redirect_pc[1:0] != 2'b00);
    assign target              = redirect_pc;

    // Sticky until reset; a later redirect resumes fetch but keeps the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else if (redirect_misaligned) begin
            misalign_reg <= 1'b1;
        end
    end

    assign fetch_misalign = misalign_reg;
`else
    assign redirect_misaligned = 1'b0;
    assign target              = redirect_pc & ~32'd3;
    assign fetch_misalign      = 1'b0;
`endif

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk      (clk),
        .reset    (reset),
        .redirect (redirect),
        .advance  (capture),
        .target   (target),
        .pc       (pc),
        .pc4      (pc4)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        port_en    = 1'b0;
        case (state_reg)
            START: state_next = RUN;
            RUN: begin
                port_en = 1'b1;
                if (!stall) begin
                    capture = 1'b1;
                    if (is_trap(imem.imem_dout[0:5])) begin
                        state_next = HALT;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = START;
        endcase
        // Redirect overrides stall and any capture in the same cycle.
        if (redirect) begin
            capture    = 1'b0;
            state_next = redirect_misaligned ? HALT : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr_reg <= NOP_WORD;
            if_id_pc4_reg   <= 32'd0;
            if_id_valid_reg <= 1'b0;
        end else if (redirect) begin
            if_id_instr_reg <= NOP_WORD;
            if_id_valid_reg <= 1'b0;
        end else if (capture) begin
            if_id_instr_reg <= imem.imem_dout;
            if_id_pc4_reg   <= pc4;
            if_id_valid_reg <= 1'b1;
        end else if (state_reg == HALT && !stall) begin
            if_id_valid_reg <= 1'b0;
        end
    end

    assign imem.imem_cs   = port_en;
    assign imem.imem_oe   = port_en;
    assign imem.imem_we   = 1'b0;
    assign imem.imem_addr = pc;

    assign if_id_instr = if_id_instr_reg;
    assign if_id_pc4   = if_id_pc4_reg;
    assign if_id_valid = if_id_valid_reg;
    assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stall/redirect/reset traffic, checked against a behavioural fetch model.
module tb_instr_fetch;
    import dlx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [0:31] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch_if imem ();

    // 64-word memory image, aliased across the whole address space.
    logic [31:0] mem [0:63];
    assign imem.imem_dout = mem[imem.imem_addr[7:2]];

    instr_fetch #(
        .RESET_PC (32'h0040_0020),
        .NOP_WORD (32'h5400_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_misalign (fetch_misalign)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the stage, expressed as "what the stage is doing".
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    bit          m_booting;
    bit          m_stopped;
    bit          m_mis;

    task automatic model_edge(input bit r, input bit s, input bit d, input logic [31:0] t);
        logic [31:0] w;
        if (r) begin
            m_pc = 32'h0040_0020; m_booting = 1; m_stopped = 0;
            m_instr = 32'h5400_0000; m_pc4 = 0; m_valid = 0; m_mis = 0;
        end else if (d) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = t;
            m_stopped = (t % 4) != 0;
            if (m_stopped) m_mis = 1;
`else
            m_pc = t - (t % 4);
            m_stopped = 0;
`endif
            m_instr = 32'h5400_0000; m_valid = 0; m_booting = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_stopped) begin
            if (!s) m_valid = 0;
        end else if (!s) begin
            w = mem[(m_pc / 4) % 64];
            m_instr = w; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            if (w[31:26] == 6'b010001) m_stopped = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem.imem_addr, m_pc);
        chk("imem_cs", {31'd0, imem.imem_cs}, {31'd0, !m_booting && !m_stopped});
        chk("imem_oe", {31'd0, imem.imem_oe}, {31'd0, !m_booting && !m_stopped});
        chk("imem_we", {31'd0, imem.imem_we}, 32'd0);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, m_stopped});
        chk("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
    endtask

    task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
        reset = r; stall = s; redirect = d; redirect_pc = t;
        @(posedge clk);
        model_edge(r, s, d, t);
        #1;
        check_all();
        $display("step rst=%0b stall=%0b redir=%0b tgt=%h -> addr=%h instr=%h valid=%0b halted=%0b",
                 r, s, d, t, imem.imem_addr, if_id_instr, if_id_valid, halted);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] t;
        bit r, s, d;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            while (w[31:26] == 6'b010001) w = $urandom;
            mem[i] = w;
        end
        mem[8]  = 32'h2001_AAAA;   // 0x00400020
        mem[12] = 32'h4400_0000;   // trap at 0x00400030

        // Reset and sequential fetch
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("first_instr", if_id_instr, 32'h2001_AAAA);
        chk("first_pc4", if_id_pc4, 32'h0040_0024);
        step(0, 0, 0, 0);

        // Three-cycle stall, then resume
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("stall_addr", imem.imem_addr, 32'h0040_0028);
        step(0, 0, 0, 0);

        // Redirect while stalled squashes
        step(0, 1, 1, 32'h0040_0020);
        chk("squash_instr", if_id_instr, 32'h5400_0000);
        chk("squash_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("redir_instr", if_id_instr, 32'h2001_AAAA);
        chk("redir_pc4", if_id_pc4, 32'h0040_0024);

        // Run into the trap at 0x00400030
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("trap_instr", if_id_instr, 32'h4400_0000);
        chk("trap_valid", {31'd0, if_id_valid}, 32'd1);
        step(0, 0, 0, 0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", imem.imem_addr, 32'h0040_0034);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0040_0020);
        step(0, 0, 0, 0);
        chk("resume_instr", if_id_instr, 32'h2001_AAAA);

        // Misaligned redirect
        step(0, 0, 1, 32'h0040_0022);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("misalign_halt", {31'd0, halted}, 32'd1);
`else
        chk("misalign_addr", imem.imem_addr, 32'h0040_0020);
`endif
        step(0, 0, 1, 32'h0040_0020);
        step(0, 0, 0, 0);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_addr", imem.imem_addr, 32'h0000_0000);
        chk("wrap_pc4", if_id_pc4, 32'h0000_0000);

        // Reset two cycles into a stall
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_addr", imem.imem_addr, 32'h0040_0020);
        chk("rst_cs", {31'd0, imem.imem_cs}, 32'd0);
        step(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = 32'h0040_0000 | ($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 3) == 0) t = t | $urandom_range(1, 3);
            step(r, s, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
